// File: rtl/cache_snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter for the per-core MESI controllers.
// Carries one bus transaction at a time: it broadcasts the command, collects snoop responses and waits out any flush.
//
// state | meaning
// IDLE  | no transaction; arbitrate among requesting cores
// SNOOP | broadcast latched command/address, sample hit/flush responses
// FLUSH | snooper write-back occupying the bus, counter running down
// DONE  | completion pulse and shared indication to the granted core
module cache_snoop_bus_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 32,
   parameter int FLUSH_CYC = 2
) (
   input  logic                        clk,
   input  logic                        rstb,
   input  logic [NUM_CORES-1:0]        req_rd,
   input  logic [NUM_CORES-1:0]        req_rdx,
   input  logic [NUM_CORES-1:0]        req_upgr,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   input  logic [NUM_CORES-1:0]        snp_hit,
   input  logic [NUM_CORES-1:0]        snp_flush,
   output logic [NUM_CORES-1:0]        snp_rd,
   output logic [NUM_CORES-1:0]        snp_rdx,
   output logic [NUM_CORES-1:0]        snp_upgr,
   output logic [ADDR_W-1:0]           snp_addr,
   output logic [NUM_CORES-1:0]        gnt,
   output logic [NUM_CORES-1:0]        done,
   output logic [NUM_CORES-1:0]        c_out,
   output logic                        busy
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic [1:0] {IDLE, SNOOP, FLUSH, DONE} stateT;

   stateT                 state, stateNext;
   logic [NUM_CORES-1:0]  gntR;
   logic [IDX_W-1:0]      gntIdx;
   logic [IDX_W-1:0]      rrPtr;
   logic [2:0]            cmdR;      // one-hot {rdx, upgr, rd}
   logic [ADDR_W-1:0]     addrR;
   logic                  sharedR;
   logic [CNT_W-1:0]      flushCnt;

   logic [NUM_CORES-1:0]  reqAny;
   logic                  pickValid;
   logic [IDX_W-1:0]      pickIdx;
   logic [2:0]            cmdPick;
   logic [ADDR_W-1:0]     addrPick;
   logic                  hitOthers;
   logic                  flushOthers;

   assign reqAny      = req_rd | req_rdx | req_upgr;
   assign hitOthers   = |(snp_hit & ~gntR);
   assign flushOthers = |(snp_flush & ~gntR);

   // First requester strictly after the last winner, wrapping around.
   always_comb begin
      int j;
      j         = 0;
      pickValid = 1'b0;
      pickIdx   = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         j = int'(rrPtr) + k;
         if (j >= NUM_CORES) j = j - NUM_CORES;
         if (!pickValid && reqAny[j[IDX_W-1:0]]) begin
            pickValid = 1'b1;
            pickIdx   = j[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      cmdPick  = 3'b001;
      addrPick = req_addr[int'(pickIdx)*ADDR_W +: ADDR_W];
      if (req_rdx[pickIdx])       cmdPick = 3'b100;
      else if (req_upgr[pickIdx]) cmdPick = 3'b010;
   end

   always_ff @(posedge clk) begin
      if (rstb) state <= IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      snp_rd    = '0;
      snp_rdx   = '0;
      snp_upgr  = '0;
      snp_addr  = '0;
      done      = '0;
      c_out     = '0;
      gnt       = gntR;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (pickValid) stateNext = SNOOP;
         end
         SNOOP: begin
            snp_rd    = {NUM_CORES{cmdR[0]}} & ~gntR;
            snp_upgr  = {NUM_CORES{cmdR[1]}} & ~gntR;
            snp_rdx   = {NUM_CORES{cmdR[2]}} & ~gntR;
            snp_addr  = addrR;
            stateNext = flushOthers ? FLUSH : DONE;
         end
         FLUSH: begin
            if (flushCnt == '0) stateNext = DONE;
         end
         DONE: begin
            done      = gntR;
            c_out     = gntR & {NUM_CORES{sharedR}};
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         gntR     <= '0;
         gntIdx   <= '0;
         rrPtr    <= IDX_W'(NUM_CORES - 1);
         cmdR     <= '0;
         addrR    <= '0;
         sharedR  <= 1'b0;
         flushCnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pickValid) begin
                  gntR   <= NUM_CORES'(1) << pickIdx;
                  gntIdx <= pickIdx;
                  cmdR   <= cmdPick;
                  addrR  <= addrPick;
               end
            end
            SNOOP: begin
               sharedR <= hitOthers;
               if (flushOthers) flushCnt <= CNT_W'(FLUSH_CYC - 1);
            end
            FLUSH: begin
               if (flushCnt != '0) flushCnt <= flushCnt - CNT_W'(1);
            end
            DONE: begin
               rrPtr <= gntIdx;
               gntR  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_snoop_bus_arbiter.sv
// Scoreboard bench for cache_snoop_bus_arbiter: a transaction-level model queues expected snoop/done events.
// A negedge monitor pops these events and compares them against the DUT outputs.
module tb_cache_snoop_bus_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int FC = 2;

   logic            clk = 1'b0;
   logic            rstb = 1'b1;
   logic [N-1:0]    reqRd = '0, reqRdx = '0, reqUpgr = '0;
   logic [N*AW-1:0] reqAddr = '0;
   logic [N-1:0]    snpHit = '0, snpFlush = '0;
   logic [N-1:0]    snpRd, snpRdx, snpUpgr, gnt, done, cOut;
   logic [AW-1:0]   snpAddr;
   logic            busy;

   cache_snoop_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .FLUSH_CYC(FC)) dut (
      .clk(clk), .rstb(rstb),
      .req_rd(reqRd), .req_rdx(reqRdx), .req_upgr(reqUpgr), .req_addr(reqAddr),
      .snp_hit(snpHit), .snp_flush(snpFlush),
      .snp_rd(snpRd), .snp_rdx(snpRdx), .snp_upgr(snpUpgr), .snp_addr(snpAddr),
      .gnt(gnt), .done(done), .c_out(cOut), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int lastWin = N - 1;

   typedef struct {
      int           cyc;
      logic [N-1:0] gnt, rd, rdx, upgr;
      logic [AW-1:0] addr;
   } snpExpT;
   typedef struct {
      int           cyc;
      logic [N-1:0] done, cOut;
   } doneExpT;

   snpExpT  snpQ[$];
   doneExpT doneQ[$];

   // Monitor: any bus broadcast or completion must match the head of its queue.
   always @(negedge clk) begin
      snpExpT  se;
      doneExpT de;
      if ((snpRd | snpRdx | snpUpgr) != '0) begin
         checks++;
         if (snpQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_snoop cyc=%0d rd=%b rdx=%b upgr=%b", cyc, snpRd, snpRdx, snpUpgr);
         end else begin
            se = snpQ.pop_front();
            if (se.cyc != cyc || se.gnt != gnt || se.rd != snpRd || se.rdx != snpRdx ||
                se.upgr != snpUpgr || se.addr != snpAddr) begin
               errors++;
               $display("FAIL snoop got cyc=%0d gnt=%b rd=%b rdx=%b upgr=%b addr=%h exp cyc=%0d gnt=%b rd=%b rdx=%b upgr=%b addr=%h",
                        cyc, gnt, snpRd, snpRdx, snpUpgr, snpAddr,
                        se.cyc, se.gnt, se.rd, se.rdx, se.upgr, se.addr);
            end
         end
      end
      if (done != '0) begin
         checks++;
         if (doneQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done cyc=%0d done=%b c_out=%b", cyc, done, cOut);
         end else begin
            de = doneQ.pop_front();
            if (de.cyc != cyc || de.done != done || de.cOut != cOut || gnt != done) begin
               errors++;
               $display("FAIL done got cyc=%0d done=%b c_out=%b gnt=%b exp cyc=%0d done=%b c_out=%b",
                        cyc, done, cOut, gnt, de.cyc, de.done, de.cOut);
            end
         end
      end else if (cOut != '0) begin
         checks++;
         errors++;
         $display("FAIL c_out_without_done cyc=%0d c_out=%b", cyc, cOut);
      end
   end

   // Requesters drop their request right after seeing their completion pulse.
   always @(negedge clk) begin
      if (!rstb) begin
         reqRd   = reqRd & ~done;
         reqRdx  = reqRdx & ~done;
         reqUpgr = reqUpgr & ~done;
      end
   end

   // Drives a set of simultaneous requests, predicts the whole round of transactions, waits for completion.
   task automatic runRound(input logic [N-1:0] rd, input logic [N-1:0] rdx, input logic [N-1:0] upgr,
                           input logic [N*AW-1:0] addrs, input logic [N-1:0] hit, input logic [N-1:0] flush);
      logic [N-1:0] pending;
      int           t;
      int           budget;
      snpExpT       se;
      doneExpT      de;
      reqRd    = rd;
      reqRdx   = rdx;
      reqUpgr  = upgr;
      reqAddr  = addrs;
      snpHit   = hit;
      snpFlush = flush;
      rstb     = 1'b0;
      pending  = rd | rdx | upgr;
      t        = cyc;
      while (pending != '0) begin
         int           w;
         logic [N-1:0] g;
         w = -1;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (lastWin + k) % N;
            if (w < 0 && pending[c]) w = c;
         end
         g       = N'(1 << w);
         se.cyc  = t + 1;
         se.gnt  = g;
         se.rd   = '0;
         se.rdx  = '0;
         se.upgr = '0;
         if (rdx[w])       se.rdx  = ~g;
         else if (upgr[w]) se.upgr = ~g;
         else              se.rd   = ~g;
         se.addr = addrs[w*AW +: AW];
         snpQ.push_back(se);
         de.cyc  = t + 2 + (((flush & ~g) != '0) ? FC : 0);
         de.done = g;
         de.cOut = ((hit & ~g) != '0) ? g : '0;
         doneQ.push_back(de);
         t          = de.cyc + 1;
         lastWin    = w;
         pending[w] = 1'b0;
      end
      budget = 0;
      while ((doneQ.size() != 0 || (reqRd | reqRdx | reqUpgr) != '0) && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) begin
         checks++;
         errors++;
         $display("FAIL round_timeout pending_done=%0d pending_snoop=%0d", doneQ.size(), snpQ.size());
         doneQ.delete();
         snpQ.delete();
         reqRd = '0; reqRdx = '0; reqUpgr = '0;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      logic [N*AW-1:0] addrs;
      logic [N-1:0]    who, rd, rdx, upgr;
      int              n;
      snpExpT          se;

      // Reset held with every core requesting: everything quiet.
      rstb  = 1'b1;
      reqRd = '1;
      for (int i = 0; i < N; i++) reqAddr[i*AW +: AW] = $urandom;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (busy || gnt != '0 || done != '0 || cOut != '0 || snpRd != '0 ||
             snpRdx != '0 || snpUpgr != '0 || snpAddr != '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b gnt=%b done=%b c_out=%b snp=%b/%b/%b addr=%h exp all zero",
                     busy, gnt, done, cOut, snpRd, snpRdx, snpUpgr, snpAddr);
         end
      end
      runRound('1, '0, '0, reqAddr, '0, '0);

      addrs = '0;
      addrs[2*AW +: AW] = 32'h40;
      runRound(4'b0100, '0, '0, addrs, '0, '0);
      runRound(4'b0010, '0, '0, addrs, 4'b1000, '0);
      runRound('0, 4'b0001, '0, addrs, '0, 4'b0010);
      for (int i = 0; i < N; i++) addrs[i*AW +: AW] = $urandom;
      runRound('1, 4'b0110, 4'b1100, addrs, 4'b0101, 4'b1001);

      // Reset during a flush aborts with no completion; the held request is then served fresh.
      reqRdx   = 4'b0001;
      reqAddr[0 +: AW] = 32'h1234_5680;
      snpHit   = '0;
      snpFlush = 4'b0010;
      n        = cyc;
      se.cyc   = n + 1;
      se.gnt   = 4'b0001;
      se.rd    = '0;
      se.rdx   = 4'b1110;
      se.upgr  = '0;
      se.addr  = 32'h1234_5680;
      snpQ.push_back(se);
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      checks++;
      if (busy || gnt != '0 || done != '0) begin
         errors++;
         $display("FAIL reset_abort busy=%b gnt=%b done=%b exp 0/0000/0000", busy, gnt, done);
      end
      lastWin = N - 1;
      runRound('0, 4'b0001, '0, reqAddr, '0, 4'b0010);

      for (int r = 0; r < 40; r++) begin
         who  = N'($urandom_range(1, (1 << N) - 1));
         rd   = '0; rdx = '0; upgr = '0;
         for (int i = 0; i < N; i++) begin
            logic [2:0] b;
            b = 3'($urandom_range(1, 7));
            if (who[i]) begin
               rd[i] = b[0]; upgr[i] = b[1]; rdx[i] = b[2];
            end
            addrs[i*AW +: AW] = $urandom;
         end
         runRound(rd, rdx, upgr, addrs, N'($urandom), N'($urandom & $urandom & $urandom));
      end

      checks++;
      if (snpQ.size() != 0 || doneQ.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations snoop=%0d done=%0d exp 0/0", snpQ.size(), doneQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
